// File: rtl/iecdrv_track_seq.sv
// Head/rotation sequencer: one port-B read or write per bit cell, byte assembly, SYNC detect.
// Optional macro IECDRV_TRACK_DIRTY_EN adds a write-back dirty flag (dirty_clr / dirty).
module iecdrv_track_seq #(
    parameter int ADDRWIDTH   = 13,
    parameter int BIT_PERIOD0 = 64,
    parameter int BIT_STEP    = 4,
    parameter int READ_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 motor_on,
    input  logic                 mode,
    input  logic [1:0]           speed_zone,
    input  logic [ADDRWIDTH+2:0] track_len,
    input  logic [7:0]           wr_byte,
    output logic [ADDRWIDTH+2:0] mem_addr,
    output logic                 mem_wdata,
    output logic                 mem_wren,
    input  logic                 mem_q,
    output logic [7:0]           rd_byte,
    output logic                 byte_rdy,
    output logic                 sync_n,
    output logic [ADDRWIDTH+2:0] bit_pos
`ifdef IECDRV_TRACK_DIRTY_EN
    ,
    input  logic                 dirty_clr,
    output logic                 dirty
`endif
);
    localparam int PW = ADDRWIDTH + 3;
    localparam int CW = $clog2(BIT_PERIOD0 + 1);
    localparam logic [PW-1:0] PONE = PW'(1);
    localparam logic [CW-1:0] CONE = CW'(1);
    localparam logic [CW-1:0] RLAT = CW'(READ_LAT);
    localparam logic [3:0]    SYNC_ONES = 4'd10;

    typedef enum logic {IDLE = 1'b0, CELL = 1'b1} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q, period_q, period_d;
    logic [PW-1:0] bit_pos_q, mem_addr_q, pos_inc_d;
    logic          mem_wdata_q, mem_wren_q, byte_rdy_q, sync_n_q, mode_q;
    logic [7:0]    rd_byte_q, rshift_q, wshift_q, wsrc_d, rbyte_d;
    logic [3:0]    ones_q, ones_d;
    logic [2:0]    bcnt_q, bcnt_w_d;
    logic          run_ok_d;

    assign run_ok_d  = motor_on && (track_len != '0);
    assign period_d  = CW'(BIT_PERIOD0) - CW'(speed_zone) * CW'(BIT_STEP);
    assign pos_inc_d = bit_pos_q + PONE;
    assign ones_d    = mem_q ? ((ones_q == SYNC_ONES) ? SYNC_ONES : ones_q + 4'd1) : 4'd0;
    assign rbyte_d   = {rshift_q[6:0], mem_q};
    // A read->write switch starts a fresh byte straight from wr_byte.
    assign wsrc_d    = mode_q ? wr_byte : wshift_q;
    assign bcnt_w_d  = mode_q ? 3'd0 : bcnt_q;

    // byte_rdy is a single-cycle strobe with no back-pressure: rd_byte is valid in the
    // strobe cycle (read), or wr_byte has just been taken and the next one may be set up (write).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            period_q    <= CW'(BIT_PERIOD0);
            bit_pos_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 1'b0;
            mem_wren_q  <= 1'b0;
            rd_byte_q   <= '0;
            byte_rdy_q  <= 1'b0;
            sync_n_q    <= 1'b1;
            ones_q      <= '0;
            bcnt_q      <= '0;
            rshift_q    <= '0;
            wshift_q    <= '0;
            mode_q      <= 1'b1;
        end else begin
            mem_wren_q <= 1'b0;
            byte_rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run_ok_d) begin
                        state_q <= CELL;
                        cnt_q   <= '0;
                    end
                end
                CELL: begin
                    if (cnt_q == '0) begin
                        if (!run_ok_d) begin
                            state_q <= IDLE;
                        end else begin
                            period_q   <= period_d;
                            mode_q     <= mode;
                            cnt_q      <= CONE;
                            mem_addr_q <= bit_pos_q;
                            if (mode) begin
                                if (!mode_q) begin
                                    ones_q <= '0;
                                    bcnt_q <= '0;
                                end
                            end else begin
                                mem_wren_q  <= 1'b1;
                                mem_wdata_q <= wsrc_d[7];
                                sync_n_q    <= 1'b1;
                                bcnt_q      <= bcnt_w_d + 3'd1;
                                if (bcnt_w_d == 3'd7) begin
                                    wshift_q   <= wr_byte;
                                    byte_rdy_q <= 1'b1;
                                end else begin
                                    wshift_q <= {wsrc_d[6:0], 1'b0};
                                end
                            end
                        end
                    end else begin
                        if (cnt_q == RLAT && mode_q) begin
                            rshift_q <= rbyte_d;
                            ones_q   <= ones_d;
                            // Sync takes priority over a byte completing in the same cell.
                            if (ones_d == SYNC_ONES) begin
                                sync_n_q <= 1'b0;
                                bcnt_q   <= '0;
                            end else begin
                                sync_n_q <= 1'b1;
                                bcnt_q   <= bcnt_q + 3'd1;
                                if (bcnt_q == 3'd7) begin
                                    rd_byte_q  <= rbyte_d;
                                    byte_rdy_q <= 1'b1;
                                end
                            end
                        end
                        if (cnt_q == period_q - CONE) begin
                            cnt_q <= '0;
                            if (motor_on) begin
                                bit_pos_q <= (pos_inc_d >= track_len) ? '0 : pos_inc_d;
                            end
                        end else begin
                            cnt_q <= cnt_q + CONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;
    assign rd_byte   = rd_byte_q;
    assign byte_rdy  = byte_rdy_q;
    assign sync_n    = sync_n_q;
    assign bit_pos   = bit_pos_q;

`ifdef IECDRV_TRACK_DIRTY_EN
    logic dirty_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dirty_q <= 1'b0;
        end else if (mem_wren_q) begin
            dirty_q <= 1'b1;
        end else if (dirty_clr) begin
            dirty_q <= 1'b0;
        end
    end

    assign dirty = dirty_q;
`endif
endmodule

// File: tb/tb_iecdrv_track_seq.sv
// Directed bench for iecdrv_track_seq: bit-level track memory model, per-scenario tasks.
module tb_iecdrv_track_seq;
  localparam int AW = 13;
  localparam int PW = AW + 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          motor_on = 1'b0;
  logic          mode = 1'b1;
  logic [1:0]    speed_zone = 2'd0;
  logic [PW-1:0] track_len = '0;
  logic [7:0]    wr_byte = '0;
  logic [PW-1:0] mem_addr;
  logic          mem_wdata;
  logic          mem_wren;
  logic          mem_q = 1'b0;
  logic [7:0]    rd_byte;
  logic          byte_rdy;
  logic          sync_n;
  logic [PW-1:0] bit_pos;
`ifdef IECDRV_TRACK_DIRTY_EN
  logic          dirty_clr = 1'b0;
  logic          dirty;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic tmem [0:255];

  iecdrv_track_seq #(.ADDRWIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .motor_on(motor_on), .mode(mode),
    .speed_zone(speed_zone), .track_len(track_len), .wr_byte(wr_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q),
    .rd_byte(rd_byte), .byte_rdy(byte_rdy), .sync_n(sync_n), .bit_pos(bit_pos)
`ifdef IECDRV_TRACK_DIRTY_EN
    , .dirty_clr(dirty_clr), .dirty(dirty)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) mem_q <= tmem[mem_addr[7:0]];

  task automatic do_reset;
    reset_n = 1'b0;
    motor_on = 1'b0;
    mode = 1'b1;
    speed_zone = 2'd0;
    track_len = '0;
    wr_byte = '0;
`ifdef IECDRV_TRACK_DIRTY_EN
    dirty_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) tmem[i] = 1'b0;
  endtask

  task automatic load_byte(input int base, input logic [7:0] b);
    for (int i = 0; i < 8; i++) tmem[base + i] = b[7 - i];
  endtask

  task automatic wait_pos(input int budget, output int t, output bit ok);
    logic [PW-1:0] p;
    p = bit_pos;
    ok = 1'b0;
    t = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bit_pos !== p) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
    end
  endtask

  task automatic wait_wren(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (mem_wren === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
    checks++; if (mem_wdata !== 1'b0) begin errors++; $display("FAIL reset_mem_wdata: got %b want 0", mem_wdata); end
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL reset_mem_wren: got %b want 0", mem_wren); end
    checks++; if (rd_byte !== 8'h00) begin errors++; $display("FAIL reset_rd_byte: got %h want 00", rd_byte); end
    checks++; if (byte_rdy !== 1'b0) begin errors++; $display("FAIL reset_byte_rdy: got %b want 0", byte_rdy); end
    checks++; if (sync_n !== 1'b1) begin errors++; $display("FAIL reset_sync_n: got %b want 1", sync_n); end
    checks++; if (bit_pos !== '0) begin errors++; $display("FAIL reset_bit_pos: got %0h want 0", bit_pos); end
  endtask

  task automatic test_read_basic;
    logic [7:0] exp_q[$];
    logic [7:0] w;
    logic [PW-1:0] prev;
    int n_chg, t_last, want_addr;
    do_reset;
    clear_mem;
    load_byte(0, 8'h55);
    load_byte(8, 8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    track_len = PW'(16);
    mode = 1'b1;
    motor_on = 1'b1;
    prev = mem_addr;
    n_chg = 0;
    t_last = 0;
    want_addr = 1;
    for (int k = 0; k < 1300 && n_chg < 16; k++) begin
      @(negedge clk);
      if (byte_rdy === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL read_extra_byte: got %h want none", rd_byte);
        end else begin
          w = exp_q.pop_front();
          if (rd_byte !== w) begin errors++; $display("FAIL read_byte: got %h want %h", rd_byte, w); end
        end
      end
      if (mem_addr !== prev) begin
        n_chg++;
        checks++;
        if (mem_addr !== PW'(want_addr)) begin
          errors++; $display("FAIL read_addr: got %0d want %0d", mem_addr, want_addr);
        end
        if (n_chg > 1) begin
          checks++;
          if (cyc - t_last != 64) begin errors++; $display("FAIL read_period: got %0d want 64", cyc - t_last); end
        end
        t_last = cyc;
        prev = mem_addr;
        want_addr = (want_addr + 1) % 16;
      end
    end
    checks++; if (n_chg != 16) begin errors++; $display("FAIL read_addr_steps: got %0d want 16", n_chg); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL read_missing_bytes: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_zone;
    int t0, t1, t2, t3;
    bit ok0, ok1, ok2, ok3;
    do_reset;
    clear_mem;
    track_len = PW'(200);
    mode = 1'b1;
    speed_zone = 2'd3;
    motor_on = 1'b1;
    wait_pos(200, t0, ok0);
    wait_pos(200, t1, ok1);
    checks++; if (!(ok0 && ok1) || t1 - t0 != 52) begin errors++; $display("FAIL zone3_period: got %0d want 52", t1 - t0); end
    repeat (10) @(negedge clk);
    speed_zone = 2'd0;
    wait_pos(200, t2, ok2);
    checks++; if (!ok2 || t2 - t1 != 52) begin errors++; $display("FAIL zone_mid_cell: got %0d want 52", t2 - t1); end
    wait_pos(200, t3, ok3);
    checks++; if (!ok3 || t3 - t2 != 64) begin errors++; $display("FAIL zone_new_period: got %0d want 64", t3 - t2); end
  endtask

  task automatic test_sync;
    logic prev_sync;
    int fall_pos, rise_pos, n_rdy_sync, n_pre;
    bit got;
    do_reset;
    clear_mem;
    for (int i = 0; i < 12; i++) tmem[i] = 1'b1;
    load_byte(12, 8'h52);
    track_len = PW'(32);
    mode = 1'b1;
    motor_on = 1'b1;
    prev_sync = 1'b1;
    fall_pos = -1;
    rise_pos = -1;
    n_rdy_sync = 0;
    n_pre = 0;
    got = 1'b0;
    for (int k = 0; k < 2500 && !got; k++) begin
      @(negedge clk);
      if (sync_n === 1'b0 && prev_sync === 1'b1) fall_pos = int'(bit_pos);
      if (sync_n === 1'b1 && prev_sync === 1'b0) rise_pos = int'(bit_pos);
      if (byte_rdy === 1'b1) begin
        if (sync_n === 1'b0) begin
          n_rdy_sync++;
        end else if (fall_pos < 0) begin
          n_pre++;
          checks++; if (rd_byte !== 8'hFF) begin errors++; $display("FAIL sync_pre_byte: got %h want ff", rd_byte); end
          checks++; if (bit_pos !== PW'(7)) begin errors++; $display("FAIL sync_pre_pos: got %0d want 7", bit_pos); end
        end else if (rise_pos >= 0) begin
          got = 1'b1;
          checks++; if (rd_byte !== 8'h52) begin errors++; $display("FAIL sync_post_byte: got %h want 52", rd_byte); end
          checks++; if (bit_pos !== PW'(19)) begin errors++; $display("FAIL sync_post_pos: got %0d want 19", bit_pos); end
        end
      end
      prev_sync = sync_n;
    end
    checks++; if (fall_pos != 9) begin errors++; $display("FAIL sync_fall_pos: got %0d want 9", fall_pos); end
    checks++; if (rise_pos != 12) begin errors++; $display("FAIL sync_rise_pos: got %0d want 12", rise_pos); end
    checks++; if (n_rdy_sync != 0) begin errors++; $display("FAIL sync_byte_rdy_in_sync: got %0d want 0", n_rdy_sync); end
    checks++; if (n_pre != 1) begin errors++; $display("FAIL sync_pre_count: got %0d want 1", n_pre); end
    checks++; if (!got) begin errors++; $display("FAIL sync_post_seen: got 0 want 1"); end
  endtask

  task automatic test_write;
    logic [PW:0] exp_q[$];
    logic [PW:0] w, obs;
    logic [7:0] wbits;
    int n, t_last, stray;
    do_reset;
    wbits = 8'hC3;
    for (int i = 0; i < 9; i++) exp_q.push_back({PW'(i % 8), wbits[7 - (i % 8)]});
    track_len = PW'(8);
    mode = 1'b0;
    wr_byte = 8'hC3;
    motor_on = 1'b1;
    n = 0;
    t_last = 0;
    stray = 0;
    for (int k = 0; k < 800 && n < 9; k++) begin
      @(negedge clk);
      if (mem_wren === 1'b1) begin
        obs = {mem_addr, mem_wdata};
        w = exp_q.pop_front();
        checks++; if (obs !== w) begin errors++; $display("FAIL write_bit %0d: got addr %0d data %b want addr %0d data %b", n, obs[PW:1], obs[0], w[PW:1], w[0]); end
        if (n > 0) begin
          checks++; if (cyc - t_last != 64) begin errors++; $display("FAIL write_period: got %0d want 64", cyc - t_last); end
        end
        checks++; if (byte_rdy !== (n == 7)) begin errors++; $display("FAIL write_byte_rdy %0d: got %b want %b", n, byte_rdy, (n == 7)); end
        t_last = cyc;
        n++;
      end else if (byte_rdy === 1'b1) begin
        stray++;
      end
    end
    checks++; if (n != 9) begin errors++; $display("FAIL write_pulses: got %0d want 9", n); end
    checks++; if (stray != 0) begin errors++; $display("FAIL write_stray_byte_rdy: got %0d want 0", stray); end
  endtask

  task automatic test_motor_stop;
    bit found, ok;
    int nw;
    logic [PW-1:0] a;
    do_reset;
    track_len = PW'(16);
    mode = 1'b0;
    wr_byte = 8'h5A;
    motor_on = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(negedge clk);
      if (mem_wren === 1'b1 && mem_addr === PW'(5)) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL motor_reach_5: got 0 want 1"); end
    repeat (20) @(negedge clk);
    motor_on = 1'b0;
    nw = 0;
    repeat (200) begin
      @(negedge clk);
      if (mem_wren === 1'b1) nw++;
    end
    checks++; if (nw != 0) begin errors++; $display("FAIL motor_off_wren: got %0d want 0", nw); end
    checks++; if (bit_pos !== PW'(5)) begin errors++; $display("FAIL motor_off_pos: got %0d want 5", bit_pos); end
    motor_on = 1'b1;
    wait_wren(200, ok);
    a = mem_addr;
    checks++; if (!ok || a !== PW'(5)) begin errors++; $display("FAIL motor_resume_addr: got %0d want 5", a); end
  endtask

  task automatic test_reset_mid_write;
    bit ok0, ok1;
    do_reset;
    track_len = PW'(8);
    mode = 1'b0;
    wr_byte = 8'hFF;
    motor_on = 1'b1;
    wait_wren(300, ok0);
    wait_wren(300, ok1);
    checks++; if (!(ok0 && ok1)) begin errors++; $display("FAIL rst_setup_wren: got 0 want 1"); end
    repeat (63) @(negedge clk);
    checks++; if (bit_pos !== PW'(2)) begin errors++; $display("FAIL rst_pre_pos: got %0d want 2", bit_pos); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b want 0", mem_wren); end
    checks++; if (mem_wdata !== 1'b0) begin errors++; $display("FAIL rst_wdata: got %b want 0", mem_wdata); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rst_addr: got %0d want 0", mem_addr); end
    checks++; if (bit_pos !== '0) begin errors++; $display("FAIL rst_pos: got %0d want 0", bit_pos); end
    checks++; if (sync_n !== 1'b1 || byte_rdy !== 1'b0 || rd_byte !== 8'h00) begin
      errors++; $display("FAIL rst_status: got sync_n %b byte_rdy %b rd_byte %h want 1 0 00", sync_n, byte_rdy, rd_byte);
    end
    motor_on = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef IECDRV_TRACK_DIRTY_EN
  task automatic test_dirty;
    bit ok;
    do_reset;
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL dirty_reset: got %b want 0", dirty); end
    track_len = PW'(8);
    mode = 1'b0;
    wr_byte = 8'h81;
    motor_on = 1'b1;
    wait_wren(300, ok);
    @(negedge clk);
    checks++; if (!ok || dirty !== 1'b1) begin errors++; $display("FAIL dirty_set: got %b want 1", dirty); end
    dirty_clr = 1'b1;
    @(negedge clk);
    dirty_clr = 1'b0;
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL dirty_clear: got %b want 0", dirty); end
    wait_wren(300, ok);
    dirty_clr = 1'b1;
    @(negedge clk);
    dirty_clr = 1'b0;
    checks++; if (!ok || dirty !== 1'b1) begin errors++; $display("FAIL dirty_set_wins: got %b want 1", dirty); end
  endtask
`endif

  initial begin
    clear_mem;
    test_reset;
    test_read_basic;
    test_zone;
    test_sync;
    test_write;
    test_motor_stop;
    test_reset_mid_write;
`ifdef IECDRV_TRACK_DIRTY_EN
    test_dirty;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
